// File: rtl/platform_pio_pkg.sv
// Shared constants for the platform switch/button input PIO.
// Register word offsets and edge-capture mode encodings.
package platform_pio_pkg;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_MASK    = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-FF synchroniser followed by a stability counter.
// stable only follows the pin after DEBOUNCE_CYCLES unchanged samples.
module pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass

    always_ff @(posedge clk) begin
      if (reset) stable <= 1'b0;
      else       stable <= sync2;
    end

  end else begin : g_count

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any sample matching stable restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

  end

endmodule

// File: rtl/platform_switch_pio.sv
// Avalon-MM input PIO: debounced DATA, maskable edge-capture interrupt.
// Edge capture is write-one-to-clear; a same-cycle new edge wins.
module platform_switch_pio
  import platform_pio_pkg::*;
#(
  parameter int          WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [31:0]      rd_mux;
  logic             wr_mask;
  logic             wr_cap;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .stable(stable[i])
    );
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  assign edge_set = (EDGE_MODE == EDGE_FALL) ? fall :
                    (EDGE_MODE == EDGE_ANY)  ? (rise | fall) :
                                               rise;

  assign wr_mask = chipselect & write & (address == PIO_MASK);
  assign wr_cap  = chipselect & write & (address == PIO_EDGECAP);
  assign clr     = wr_cap ? writedata[WIDTH-1:0] : '0;

  assign unused_wd = ^(writedata >> WIDTH);

  always_comb begin
    rd_mux = '0;
    unique case (address)
      PIO_DATA:    rd_mux[WIDTH-1:0] = stable;
      PIO_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
      PIO_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d     <= stable;
      readdata     <= rd_mux;
      irq          <= |(edge_capture & irq_mask);
      edge_capture <= (edge_capture & ~clr) | edge_set;
      if (wr_mask) irq_mask <= writedata[WIDTH-1:0];
    end
  end

endmodule
